// File: rtl/pwm_bank_pkg.sv
// Shared CSR widths, CTRL register layout and period decode for the PWM bank.
package pwm_bank_pkg;

  localparam int unsigned CSR_AW       = 5;
  localparam int unsigned CSR_DW       = 8;
  localparam int unsigned CNT_W        = 8;
  localparam int unsigned PWM_CTRL_EN  = 7;
  localparam int unsigned PWM_CTRL_INV = 6;
  localparam int unsigned MODE_MSB     = 1;
  localparam int unsigned MODE_LSB     = 0;

  typedef enum logic [1:0] {
    MODE_P256 = 2'd0,
    MODE_P128 = 2'd1,
    MODE_P64  = 2'd2,
    MODE_P32  = 2'd3
  } pwm_mode_e;

  typedef struct packed {
    logic      en;
    logic      inv;
    logic [3:0] rsvd;
    pwm_mode_e mode;
  } pwm_ctrl_t;

  // Last count value of a period (P-1) for each mode.
  function automatic logic [CNT_W-1:0] period_last(input pwm_mode_e mode);
    case (mode)
      MODE_P256: return CNT_W'(255);
      MODE_P128: return CNT_W'(127);
      MODE_P64:  return CNT_W'(63);
      default:   return CNT_W'(31);
    endcase
  endfunction

  // Reserved CTRL bits are dropped on write so they always read back as zero.
  function automatic pwm_ctrl_t ctrl_from_wdata(input logic [CSR_DW-1:0] d);
    pwm_ctrl_t c;
    c.en   = d[PWM_CTRL_EN];
    c.inv  = d[PWM_CTRL_INV];
    c.rsvd = 4'b0000;
    c.mode = pwm_mode_e'(d[MODE_MSB:MODE_LSB]);
    return c;
  endfunction

endpackage

// File: rtl/pwm_channel.sv
// One PWM channel: CTRL, duty shadow/active pair, period counter and registered output.
module pwm_channel
  import pwm_bank_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pwm_ce,
  input  logic              ctrl_we,
  input  logic              duty_we,
  input  logic [CSR_DW-1:0] wdata,
  output logic [CSR_DW-1:0] ctrl_rd,
  output logic [CSR_DW-1:0] duty_rd,
  output logic              pwm_out,
  output logic              pwm_en
);

  pwm_ctrl_t        ctrl_q, ctrl_d;
  logic [CNT_W-1:0] shadow_q, shadow_d;
  logic [CNT_W-1:0] active_q, active_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pwm_out_q, pwm_out_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q    <= '0;
      shadow_q  <= '0;
      active_q  <= '0;
      cnt_q     <= '0;
      pwm_out_q <= 1'b0;
    end else begin
      ctrl_q    <= ctrl_d;
      shadow_q  <= shadow_d;
      active_q  <= active_d;
      cnt_q     <= cnt_d;
      pwm_out_q <= pwm_out_d;
    end
  end

  always_comb begin
    ctrl_d   = ctrl_q;
    shadow_d = shadow_q;
    active_d = active_q;
    cnt_d    = cnt_q;

    // Active duty only moves at the wrap, so a period never sees a mid-cycle change.
    if (ctrl_q.en) begin
      if (pwm_ce) begin
        if (cnt_q >= period_last(ctrl_q.mode)) begin
          cnt_d    = '0;
          active_d = shadow_q;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    end else begin
      cnt_d = '0;
    end

    if (duty_we) begin
      shadow_d = wdata;
      if (!ctrl_q.en) begin
        active_d = wdata;
      end
    end

    // Disable clears the counter; enable restarts a full-length period from the shadow.
    if (ctrl_we) begin
      ctrl_d = ctrl_from_wdata(wdata);
      if (!ctrl_d.en || !ctrl_q.en) begin
        cnt_d = '0;
      end
      if (ctrl_d.en && !ctrl_q.en) begin
        active_d = shadow_q;
      end
    end

    pwm_out_d = ctrl_q.en && ((cnt_q < active_q) ^ ctrl_q.inv);
  end

  assign ctrl_rd = ctrl_q;
  assign duty_rd = shadow_q;
  assign pwm_out = pwm_out_q;
  assign pwm_en  = ctrl_q.en;

endmodule

// File: rtl/pwm_bank.sv
// NUM_CH-channel PWM controller on the CSR bus: address decode, write strobes and read mux.
module pwm_bank
  import pwm_bank_pkg::*;
#(
  parameter logic [CSR_AW-1:0] BASE_ADDR = 5'h0c,
  parameter int unsigned       NUM_CH    = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pwm_ce,
  input  logic [CSR_AW-1:0] csr_a,
  input  logic [CSR_DW-1:0] csr_di,
  input  logic              csr_we,
  output logic [CSR_DW-1:0] csr_do,
  output logic [NUM_CH-1:0] pwm_out,
  output logic [NUM_CH-1:0] pwm_en
);

  // One extra bit so BASE_ADDR + 2*NUM_CH cannot overflow at the top of the map.
  localparam int unsigned OFF_W = CSR_AW + 1;

  logic [OFF_W-1:0]  offset_c;
  logic              in_win_c;
  logic [NUM_CH-1:0] ctrl_sel_c;
  logic [NUM_CH-1:0] duty_sel_c;
  logic [CSR_DW-1:0] ctrl_rd [NUM_CH];
  logic [CSR_DW-1:0] duty_rd [NUM_CH];

  assign offset_c = OFF_W'(csr_a) - OFF_W'(BASE_ADDR);
  assign in_win_c = (csr_a >= BASE_ADDR) && (offset_c < OFF_W'(2 * NUM_CH));

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    assign ctrl_sel_c[k] = in_win_c && (offset_c == OFF_W'(2 * k));
    assign duty_sel_c[k] = in_win_c && (offset_c == OFF_W'(2 * k + 1));

    pwm_channel u_ch (
      .clk     (clk),
      .rst_n   (rst_n),
      .pwm_ce  (pwm_ce),
      .ctrl_we (csr_we && ctrl_sel_c[k]),
      .duty_we (csr_we && duty_sel_c[k]),
      .wdata   (csr_di),
      .ctrl_rd (ctrl_rd[k]),
      .duty_rd (duty_rd[k]),
      .pwm_out (pwm_out[k]),
      .pwm_en  (pwm_en[k])
    );
  end

  // Read data is zero outside the window so it can be OR-combined with other slaves.
  always_comb begin
    csr_do = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      if (ctrl_sel_c[k]) begin
        csr_do = ctrl_rd[k];
      end
      if (duty_sel_c[k]) begin
        csr_do = duty_rd[k];
      end
    end
  end

endmodule

// File: tb/tb_pwm_bank.sv
// Directed bench for pwm_bank: vector tables for PWM duty/period and CSR decode, plus
// hand-written sequences for reset, disable timing and the wrap-edge duty write.
module tb_pwm_bank;

  typedef enum int {OP_WR, OP_RD, OP_EN, OP_MEAS} op_e;

  typedef struct {
    op_e         op;
    logic [4:0]  a;
    logic [7:0]  d;
    int          ch;
    int          n;
    int          exp;
    string       name;
  } vec_t;

  logic       clk;
  logic       rst_n;
  logic       pwm_ce;
  logic [4:0] csr_a;
  logic [7:0] csr_di;
  logic       csr_we;
  logic [7:0] csr_do;
  logic [1:0] pwm_out;
  logic [1:0] pwm_en;

  logic [1:0] ce_div;
  int         n_cmp;
  int         n_bad;
  bit         at_ce;
  vec_t       tv_pwm[$];
  vec_t       tv_dec[$];

  pwm_bank #(.BASE_ADDR(5'h0c), .NUM_CH(2)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .pwm_ce  (pwm_ce),
    .csr_a   (csr_a),
    .csr_di  (csr_di),
    .csr_we  (csr_we),
    .csr_do  (csr_do),
    .pwm_out (pwm_out),
    .pwm_en  (pwm_en)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // PWM tick every 4th clock, changed just after the rising edge.
  initial begin
    ce_div = 2'd0;
    pwm_ce = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      ce_div = ce_div + 2'd1;
      pwm_ce = (ce_div == 2'd3);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, n_cmp=%0d", n_cmp);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance to the falling edge just before the next clock that carries pwm_ce.
  task automatic sync_ce();
    int guard;
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (!pwm_ce && guard < 16);
    if (!pwm_ce) check("sync_ce_timeout", 0, 1);
    at_ce = 1'b1;
  endtask

  // Writes land on a pwm_ce edge so tick counting stays aligned with the DUT.
  task automatic csr_wr(input logic [4:0] a, input logic [7:0] d);
    if (!at_ce) sync_ce();
    csr_a  = a;
    csr_di = d;
    csr_we = 1'b1;
    @(negedge clk);
    csr_we = 1'b0;
    at_ce  = 1'b0;
  endtask

  task automatic csr_rd_check(input string name, input logic [4:0] a, input int exp);
    csr_a = a;
    #1;
    check(name, int'(csr_do), exp);
  endtask

  // One sample per tick: the value reflects the counter after the previous tick edge.
  task automatic measure(input int ch, input int n, output int highs);
    highs = 0;
    repeat (n) begin
      sync_ce();
      if (pwm_out[1'(ch)]) highs++;
    end
  endtask

  task automatic run_vec(input vec_t v);
    int h;
    case (v.op)
      OP_WR:   csr_wr(v.a, v.d);
      OP_RD:   csr_rd_check(v.name, v.a, v.exp);
      OP_EN:   check(v.name, int'(pwm_en), v.exp);
      default: begin
        measure(v.ch, v.n, h);
        check(v.name, h, v.exp);
      end
    endcase
  endtask

  function automatic vec_t mk(input op_e op, input logic [4:0] a, input logic [7:0] d,
                              input int ch, input int n, input int exp, input string name);
    vec_t v;
    v.op = op; v.a = a; v.d = d; v.ch = ch; v.n = n; v.exp = exp; v.name = name;
    return v;
  endfunction

  initial begin
    int h;
    n_cmp  = 0;
    n_bad  = 0;
    at_ce  = 1'b0;
    csr_a  = 5'h00;
    csr_di = 8'h00;
    csr_we = 1'b0;
    rst_n  = 1'b1;

    // Duty/period behaviour on ch0 (P=256 unless noted); tick 0 is the enable write.
    tv_pwm.push_back(mk(OP_WR,   5'h0d, 8'h40, 0,   0,   0, "duty40"));
    tv_pwm.push_back(mk(OP_WR,   5'h0c, 8'h80, 0,   0,   0, "en"));
    tv_pwm.push_back(mk(OP_MEAS, 5'h00, 8'h00, 0, 768, 192, "duty25_3periods"));
    tv_pwm.push_back(mk(OP_MEAS, 5'h00, 8'h00, 0, 100,  64, "head_of_period"));
    tv_pwm.push_back(mk(OP_WR,   5'h0d, 8'hc0, 0,   0,   0, "duty_c0_mid"));
    tv_pwm.push_back(mk(OP_MEAS, 5'h00, 8'h00, 0, 156,   0, "tail_keeps_old_duty"));
    tv_pwm.push_back(mk(OP_MEAS, 5'h00, 8'h00, 0, 256, 192, "next_period_c0"));
    tv_pwm.push_back(mk(OP_WR,   5'h0d, 8'h10, 0,   0,   0, "duty_10_at_wrap"));
    tv_pwm.push_back(mk(OP_MEAS, 5'h00, 8'h00, 0, 256, 192, "wrap_write_delayed"));
    tv_pwm.push_back(mk(OP_MEAS, 5'h00, 8'h00, 0, 256,  16, "wrap_write_applied"));
    tv_pwm.push_back(mk(OP_WR,   5'h0c, 8'h00, 0,   0,   0, "dis"));
    tv_pwm.push_back(mk(OP_MEAS, 5'h00, 8'h00, 0,   4,   0, "disabled_low"));
    tv_pwm.push_back(mk(OP_WR,   5'h0d, 8'h10, 0,   0,   0, "duty10"));
    tv_pwm.push_back(mk(OP_WR,   5'h0c, 8'h83, 0,   0,   0, "en_p32"));
    tv_pwm.push_back(mk(OP_MEAS, 5'h00, 8'h00, 0, 128,  64, "p32_half"));
    tv_pwm.push_back(mk(OP_WR,   5'h0d, 8'h20, 0,   0,   0, "duty20_at_wrap"));
    tv_pwm.push_back(mk(OP_MEAS, 5'h00, 8'h00, 0,  32,  16, "p32_old_duty"));
    tv_pwm.push_back(mk(OP_MEAS, 5'h00, 8'h00, 0,  64,  64, "duty_eq_p_const_high"));
    tv_pwm.push_back(mk(OP_WR,   5'h0d, 8'hff, 0,   0,   0, "dutyff"));
    tv_pwm.push_back(mk(OP_MEAS, 5'h00, 8'h00, 0,  64,  64, "duty_gt_p_const_high"));
    tv_pwm.push_back(mk(OP_WR,   5'h0d, 8'h00, 0,   0,   0, "duty00"));
    tv_pwm.push_back(mk(OP_MEAS, 5'h00, 8'h00, 0,  32,  32, "duty0_pending"));
    tv_pwm.push_back(mk(OP_MEAS, 5'h00, 8'h00, 0,  64,   0, "duty0_const_low"));
    tv_pwm.push_back(mk(OP_WR,   5'h0c, 8'h00, 0,   0,   0, "dis2"));
    tv_pwm.push_back(mk(OP_WR,   5'h0d, 8'h40, 0,   0,   0, "duty40b"));
    tv_pwm.push_back(mk(OP_WR,   5'h0c, 8'hc0, 0,   0,   0, "en_inv"));
    tv_pwm.push_back(mk(OP_MEAS, 5'h00, 8'h00, 0, 512, 384, "inverted_high192"));

    // Address decode and readback; ch0 is CTRL=0x00, shadow=0x40 at this point.
    tv_dec.push_back(mk(OP_WR,   5'h0f, 8'h08, 0,   0,    0, "ch1_duty"));
    tv_dec.push_back(mk(OP_WR,   5'h0e, 8'h81, 0,   0,    0, "ch1_ctrl"));
    tv_dec.push_back(mk(OP_RD,   5'h0c, 8'h00, 0,   0, 'h00, "rd_ch0_ctrl"));
    tv_dec.push_back(mk(OP_RD,   5'h0d, 8'h00, 0,   0, 'h40, "rd_ch0_duty"));
    tv_dec.push_back(mk(OP_RD,   5'h0e, 8'h00, 0,   0, 'h81, "rd_ch1_ctrl"));
    tv_dec.push_back(mk(OP_RD,   5'h0f, 8'h00, 0,   0, 'h08, "rd_ch1_duty"));
    tv_dec.push_back(mk(OP_RD,   5'h10, 8'h00, 0,   0, 'h00, "rd_above_window"));
    tv_dec.push_back(mk(OP_RD,   5'h0b, 8'h00, 0,   0, 'h00, "rd_below_window"));
    tv_dec.push_back(mk(OP_EN,   5'h00, 8'h00, 0,   0,    2, "en_ch1_only"));
    tv_dec.push_back(mk(OP_WR,   5'h10, 8'haa, 0,   0,    0, "wr_above"));
    tv_dec.push_back(mk(OP_WR,   5'h0b, 8'h55, 0,   0,    0, "wr_below"));
    tv_dec.push_back(mk(OP_RD,   5'h0c, 8'h00, 0,   0, 'h00, "rd_ch0_ctrl_after_stray"));
    tv_dec.push_back(mk(OP_RD,   5'h0f, 8'h00, 0,   0, 'h08, "rd_ch1_duty_after_stray"));
    tv_dec.push_back(mk(OP_MEAS, 5'h00, 8'h00, 1, 256,   16, "ch1_p128_duty8"));
    tv_dec.push_back(mk(OP_WR,   5'h0c, 8'hff, 0,   0,    0, "ch0_ctrl_ff"));
    tv_dec.push_back(mk(OP_RD,   5'h0c, 8'h00, 0,   0, 'hc3, "rd_ctrl_rsvd_masked"));
    tv_dec.push_back(mk(OP_MEAS, 5'h00, 8'h00, 0,  64,    0, "inv_const_active_low"));
    tv_dec.push_back(mk(OP_EN,   5'h00, 8'h00, 0,   0,    3, "en_both"));

    // Reset state.
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_pwm_out", int'(pwm_out), 0);
    check("rst_pwm_en",  int'(pwm_en), 0);
    for (int a = 'h0c; a <= 'h0f; a++) csr_rd_check("rst_read", 5'(a), 0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tv_pwm[i]) run_vec(tv_pwm[i]);

    // Disable while output is high: pwm_en drops at the write edge, pwm_out one clock later.
    csr_wr(5'h0c, 8'h00);
    check("dis_en_now",   int'(pwm_en[0]), 0);
    check("dis_out_hold", int'(pwm_out[0]), 1);
    @(negedge clk);
    check("dis_out_next", int'(pwm_out[0]), 0);
    at_ce = 1'b0;

    foreach (tv_dec[i]) run_vec(tv_dec[i]);

    // Asynchronous reset in the middle of a period with ch0 driving high.
    csr_wr(5'h0c, 8'h00);
    csr_wr(5'h0d, 8'hff);
    csr_wr(5'h0c, 8'h80);
    measure(0, 8, h);
    check("pre_rst_high", h, 8);
    @(posedge clk);
    #2;
    check("pre_rst_out0", int'(pwm_out[0]), 1);
    rst_n = 1'b0;
    #1;
    check("async_rst_out", int'(pwm_out), 0);
    check("async_rst_en",  int'(pwm_en), 0);
    csr_rd_check("async_rst_rd0c", 5'h0c, 0);
    csr_rd_check("async_rst_rd0d", 5'h0d, 0);
    csr_rd_check("async_rst_rd0e", 5'h0e, 0);
    csr_rd_check("async_rst_rd0f", 5'h0f, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    measure(0, 16, h);
    check("post_rst_idle", h, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
